// File: rtl/e1_q_pkg.sv
// Shared definitions for the E1 fixed-point adder family: default word format,
// the accumulation sequencer state encoding and the signed-add overflow rule.
package e1_q_pkg;

  localparam int E1_N = 64;
  localparam int E1_Q = 49;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIRST = 3'd1,
    S_FETCH = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } qacc_state_t;

  // Takes the sign bits of operand a, operand b and result c: overflow when the
  // operands agree in sign and the result does not.
  function automatic logic q_add_ovf(input logic a, input logic b, input logic c);
    return (a == b) && (c != a);
  endfunction

endpackage

// File: rtl/e1_qacc_seq_if.sv
// Bundle of the sequencer's sample stream, adder handshake and result signals.
// Valid/ready: a sample moves on every rising clk where in_valid & in_ready.
interface e1_qacc_seq_if
  import e1_q_pkg::*;
#(
  parameter int N  = E1_N,
  parameter int LW = 16
);
  logic              start;
  logic [LW-1:0]     len;
  logic [N-1:0]      in_data;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      add_a;
  logic              add_a_en;
  logic [N-1:0]      add_b;
  logic              add_b_en;
  logic [N-1:0]      add_c;
  logic              add_c_valid;
  logic [N-1:0]      sum;
  logic              sum_valid;
  logic              ovf;
  logic              tmo_err;
  logic              busy;
  qacc_state_t       state;

  modport master (
    output start, len, in_data, in_valid, add_c, add_c_valid,
    input  in_ready, add_a, add_a_en, add_b, add_b_en,
    input  sum, sum_valid, ovf, tmo_err, busy, state
  );

  modport slave (
    input  start, len, in_data, in_valid, add_c, add_c_valid,
    output in_ready, add_a, add_a_en, add_b, add_b_en,
    output sum, sum_valid, ovf, tmo_err, busy, state
  );
endinterface

// File: rtl/e1_qacc_seq.sv
// Batch accumulation sequencer: sums len fixed-point samples through an external
// adder with a strobe/valid handshake, one request outstanding at a time.
module e1_qacc_seq
  import e1_q_pkg::*;
#(
  parameter int N   = E1_N,
  parameter int Q   = E1_Q,
  parameter int LW  = 16,
  parameter int TMO = 255
) (
  input logic          clk,
  input logic          rst,
  e1_qacc_seq_if.slave bus
);

  localparam int CW = $clog2(TMO + 1);

  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("e1_qacc_seq: Q must lie in [0, N)");
  end
  if (TMO < 1) begin : g_bad_tmo
    $error("e1_qacc_seq: TMO must be at least 1");
  end

  qacc_state_t   r_state;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_samp;
  logic [LW-1:0] r_rem;
  logic          r_ovf;
  logic [CW-1:0] r_tmo_cnt;
  logic [N-1:0]  r_add_a;
  logic [N-1:0]  r_add_b;
  logic [N-1:0]  r_sum;
  logic          r_sum_ovf;

  logic w_in_ready;
  logic w_hs;
  logic w_ovf_next;
  logic w_tmo_hit;

  assign w_in_ready = (r_state == S_FIRST) || (r_state == S_FETCH);
  assign w_hs       = bus.in_valid & w_in_ready;
  assign w_ovf_next = r_ovf | q_add_ovf(r_acc[N-1], r_samp[N-1], bus.add_c[N-1]);
  // A result arriving in the deadline cycle wins over the timeout.
  assign w_tmo_hit  = (r_state == S_WAIT) && !bus.add_c_valid && (r_tmo_cnt == CW'(TMO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_samp    <= '0;
      r_rem     <= '0;
      r_ovf     <= 1'b0;
      r_tmo_cnt <= '0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_sum     <= '0;
      r_sum_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rem <= bus.len;
            r_acc <= '0;
            r_ovf <= 1'b0;
            if (bus.len == '0) begin
              r_sum     <= '0;
              r_sum_ovf <= 1'b0;
              r_state   <= S_DONE;
            end else begin
              r_state <= S_FIRST;
            end
          end
        end
        S_FIRST: begin
          if (w_hs) begin
            r_acc <= bus.in_data;
            r_rem <= r_rem - LW'(1);
            if (r_rem == LW'(1)) begin
              r_sum     <= bus.in_data;
              r_sum_ovf <= r_ovf;
              r_state   <= S_DONE;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          // Operand registers load here so they are stable for the whole strobe
          // cycle and keep their value until the next request.
          if (w_hs) begin
            r_samp  <= bus.in_data;
            r_add_a <= r_acc;
            r_add_b <= bus.in_data;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tmo_cnt <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.add_c_valid) begin
            r_acc <= bus.add_c;
            r_ovf <= w_ovf_next;
            r_rem <= r_rem - LW'(1);
            if (r_rem == LW'(1)) begin
              r_sum     <= bus.add_c;
              r_sum_ovf <= w_ovf_next;
              r_state   <= S_DONE;
            end else begin
              r_state <= S_FETCH;
            end
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.add_a_en  = (r_state == S_ISSUE);
  assign bus.add_b_en  = (r_state == S_ISSUE);
  assign bus.sum       = r_sum;
  assign bus.ovf       = r_sum_ovf;
  assign bus.sum_valid = (r_state == S_DONE);
  assign bus.tmo_err   = w_tmo_hit;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.state     = r_state;

endmodule

// File: tb/tb_e1_qacc_seq.sv
// Bench for e1_qacc_seq: directed batches plus randomized batches against an
// exact-arithmetic reference, with a behavioural adder of variable latency.
module tb_e1_qacc_seq;
  import e1_q_pkg::*;

  localparam int N  = 64;
  localparam int LW = 16;
  localparam int W  = N + 1;
  localparam logic signed [N+1:0] MAXP = {3'b000, {(N-1){1'b1}}};
  localparam logic signed [N+1:0] MINP = {3'b111, {(N-1){1'b0}}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  e1_qacc_seq_if #(.N(N), .LW(LW)) bus ();

  e1_qacc_seq #(.N(N), .Q(49), .LW(LW), .TMO(255)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [N-1:0] samp_q[$];
  int strobe_cnt = 0;
  int inr_cnt    = 0;
  int tmo_cnt    = 0;
  int sv_cnt     = 0;
  bit adder_on   = 1'b1;
  bit stray_req  = 1'b0;
  int lat_min    = 1;
  int lat_max    = 1;
  int gap_max    = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.add_a_en) strobe_cnt++;
      if (bus.in_ready) inr_cnt++;
      if (bus.tmo_err) tmo_cnt++;
      if (bus.add_a_en || bus.add_b_en)
        check("strobe_pair", 64'(bus.add_b_en), 64'(bus.add_a_en));
      if (bus.sum_valid) begin
        sv_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sum_valid actual=%h expected=none", bus.sum);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("sum", bus.sum, e[N-1:0]);
          check("ovf", 64'(bus.ovf), 64'(e[N]));
        end
      end
    end
  end

  // ---------------- behavioural adder ----------------
  initial begin
    logic [N-1:0] a, b;
    int l;
    bus.add_c = '0;
    bus.add_c_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (stray_req) begin
        @(posedge clk); #1;
        bus.add_c = {$urandom(), $urandom()};
        bus.add_c_valid = 1'b1;
        @(posedge clk); #1;
        bus.add_c_valid = 1'b0;
        stray_req = 1'b0;
      end else if (bus.add_a_en && adder_on && !rst) begin
        a = bus.add_a;
        b = bus.add_b;
        l = $urandom_range(lat_max, lat_min);
        repeat (l) @(posedge clk);
        #1;
        bus.add_c = a + b;
        bus.add_c_valid = 1'b1;
        @(posedge clk); #1;
        bus.add_c_valid = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_push();
    logic [N-1:0] acc;
    logic signed [N+1:0] full;
    bit ov;
    acc = '0;
    ov = 1'b0;
    for (int i = 0; i < samp_q.size(); i++) begin
      if (i == 0) begin
        acc = samp_q[i];
      end else begin
        full = $signed({{2{acc[N-1]}}, acc}) + $signed({{2{samp_q[i][N-1]}}, samp_q[i]});
        if (full > MAXP || full < MINP) ov = 1'b1;
        acc = full[N-1:0];
      end
    end
    exp_q.push_back({ov, acc});
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_batch(input int n);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len = n[LW-1:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_samples();
    logic [N-1:0] d;
    logic hs;
    int guard;
    while (samp_q.size() > 0) begin
      d = samp_q.pop_front();
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data = d;
      guard = 0;
      forever begin
        @(negedge clk);
        hs = bus.in_ready;
        @(posedge clk); #1;
        if (hs) break;
        guard++;
        if (guard > 5000) begin
          checks++;
          errors++;
          $display("FAIL handshake_timeout actual=no_ready expected=ready");
          bus.in_valid = 1'b0;
          samp_q.delete();
          return;
        end
      end
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    checks++;
    if (k >= 3000) begin
      errors++;
      $display("FAIL %s_idle actual=busy expected=idle", name);
    end
  endtask

  task automatic run_batch(input string name);
    int n;
    n = samp_q.size();
    model_push();
    start_batch(n);
    send_samples();
    wait_idle(name);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({name, "_add_en"}, 64'({bus.add_a_en, bus.add_b_en}), 64'd0);
    check({name, "_add_a"}, bus.add_a, 64'd0);
    check({name, "_add_b"}, bus.add_b, 64'd0);
    check({name, "_sum"}, bus.sum, 64'd0);
    check({name, "_flags"}, 64'({bus.sum_valid, bus.ovf, bus.tmo_err, bus.busy}), 64'd0);
    check({name, "_state"}, 64'(bus.state), 64'(S_IDLE));
  endtask

  task automatic wait_strobe(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (bus.add_a_en) break;
    end
    checks++;
    if (k >= 3000) begin
      errors++;
      $display("FAIL %s_strobe actual=none expected=strobe", name);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0, i0, t0, v0, cnt;
    logic [N-1:0] r;
    bus.start = 1'b0;
    bus.len = '0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_zero("after_reset");

    // len=3: 1.0 + 2.5 - 0.75 = 2.75, adder latency 1
    lat_min = 1; lat_max = 1; gap_max = 0;
    s0 = strobe_cnt;
    samp_q = '{64'h0002_0000_0000_0000, 64'h0005_0000_0000_0000, 64'hFFFE_8000_0000_0000};
    run_batch("len3");
    check("len3_strobes", 64'(strobe_cnt - s0), 64'd2);
    check("len3_sum_hold", bus.sum, 64'h0005_8000_0000_0000);
    check("len3_ovf_hold", 64'(bus.ovf), 64'd0);

    // len=0: done one cycle after start, no ready, no strobes
    s0 = strobe_cnt; i0 = inr_cnt;
    samp_q.delete();
    model_push();
    start_batch(0);
    @(negedge clk);
    check("len0_sum_valid", 64'(bus.sum_valid), 64'd1);
    check("len0_sum", bus.sum, 64'd0);
    wait_idle("len0");
    check("len0_in_ready", 64'(inr_cnt - i0), 64'd0);
    check("len0_strobes", 64'(strobe_cnt - s0), 64'd0);

    // signed overflow on max positive + lsb
    samp_q = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001};
    run_batch("ovf");
    check("ovf_sum_hold", bus.sum, 64'h8000_0000_0000_0000);
    check("ovf_flag_hold", 64'(bus.ovf), 64'd1);

    // result landing exactly at the deadline cycle is accepted
    lat_min = 256; lat_max = 256;
    t0 = tmo_cnt;
    samp_q = '{64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004};
    run_batch("deadline");
    check("deadline_no_tmo", 64'(tmo_cnt - t0), 64'd0);

    // adder never answers: timeout
    adder_on = 1'b0;
    v0 = sv_cnt;
    samp_q = '{64'h0000_0000_0000_0011, 64'h0000_0000_0000_0022};
    start_batch(2);
    send_samples();
    wait_strobe("tmo");
    cnt = 0;
    while (cnt < 400) begin
      @(negedge clk);
      cnt++;
      if (bus.tmo_err) break;
    end
    check("tmo_latency", 64'(cnt), 64'd256);
    @(negedge clk);
    check("tmo_pulse_end", 64'(bus.tmo_err), 64'd0);
    check("tmo_busy_drop", 64'(bus.busy), 64'd0);
    check("tmo_no_sum_valid", 64'(sv_cnt - v0), 64'd0);

    // reset while waiting, then a stray result
    samp_q = '{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0006};
    start_batch(2);
    send_samples();
    wait_strobe("rst_mid");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    @(posedge clk); #1 rst = 1'b0;
    stray_req = 1'b1;
    repeat (5) @(negedge clk);
    check_zero("post_stray");
    adder_on = 1'b1;
    lat_min = 1; lat_max = 3;
    samp_q = '{64'hFFFE_0000_0000_0000};
    run_batch("neg_one");
    check("neg_one_sum_hold", bus.sum, 64'hFFFE_0000_0000_0000);

    // randomized batches
    lat_min = 1; lat_max = 20; gap_max = 3;
    for (int b = 0; b < 100; b++) begin
      samp_q.delete();
      for (int k = 0; k < $urandom_range(16, 1); k++) begin
        r = {$urandom(), $urandom()};
        r = $signed(r) >>> $urandom_range(16, 4);
        samp_q.push_back(r);
      end
      run_batch("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog actual=running expected=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
